// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification
// for the accumulator CPU fetch/decode/issue sequencer.
// Opcodes are held in a normalized 6-bit form; 4-bit ops carry 2'b00 on top.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_BRANCH    = 2'd3
    } state_t;

    // 4-bit ops, zero-extended to 6 bits
    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_SUB    = 6'b000001;
    localparam logic [5:0] OP_MUL    = 6'b000010;
    localparam logic [5:0] OP_MOV    = 6'b000100;
    localparam logic [5:0] OP_NOP    = 6'b000111;
    // 6-bit ops (bit 5 always set, so no overlap with the 4-bit space)
    localparam logic [5:0] OP_LD_IMM = 6'b100000;
    localparam logic [5:0] OP_CMP    = 6'b100011;
    localparam logic [5:0] OP_DEC    = 6'b100101;
    localparam logic [5:0] OP_INPUT  = 6'b100110;
    localparam logic [5:0] OP_OUTPUT = 6'b100111;
    localparam logic [5:0] OP_BRA    = 6'b101010;
    localparam logic [5:0] OP_BHI    = 6'b101100;
    localparam logic [5:0] OP_BEQ    = 6'b101101;

    typedef struct packed {
        logic legal;
        logic two_byte;
        logic branch;
    } op_class_t;

    // Classify a normalized opcode; undefined opcodes come back all-zero.
    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_NOP,
            OP_DEC, OP_INPUT, OP_OUTPUT:  c.legal = 1'b1;
            OP_LD_IMM, OP_CMP:            c = '{legal: 1'b1, two_byte: 1'b1, branch: 1'b0};
            OP_BRA, OP_BHI, OP_BEQ:       c = '{legal: 1'b1, two_byte: 1'b1, branch: 1'b1};
            default:                      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Instruction byte decoder: splits a ROM byte into normalized opcode and register fields.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is used.
module instr_decoder
    import instr_sequencer_pkg::*;
(
    input  logic [7:0] instr_byte,
    output logic [5:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic       two_byte,
    output logic       branch,
    output logic       legal
);

    op_class_t op_class;

    // Bit 7 selects between the 4-bit two-register form and the 6-bit one-register form
    always_comb begin
        opcode = '0;
        rd     = '0;
        rs     = '0;
        if (instr_byte[7]) begin
            opcode = instr_byte[7:2];
            rd     = instr_byte[1:0];
        end else begin
            opcode = {2'b00, instr_byte[7:4]};
            rd     = instr_byte[3:2];
            rs     = instr_byte[1:0];
        end
        op_class = classify(opcode);
        two_byte = op_class.two_byte;
        branch   = op_class.branch;
        legal    = op_class.legal;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue controller: fetches 1-2 byte instructions, resolves branches, issues micro-ops.
// Latency: 1-byte op 2 cycles, 2-byte op 3 cycles minimum, branch exactly 3 cycles.
// Backpressure: micro-op held stable in ISSUE until uop_ready; run=0 stalls only in FETCH.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                  ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] pc,
    input  logic [7:0]        instr_byte,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [5:0]        uop_opcode,
    output logic [1:0]        uop_rd,
    output logic [1:0]        uop_rs,
    output logic [7:0]        uop_imm,
    input  logic              flag_z,
    input  logic              flag_hi,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    state_t     state;
    logic [5:0] dec_opcode;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs;
    logic       dec_two_byte;
    logic       dec_branch;
    logic       dec_legal;

    // First byte of a 2-byte op is parked here while the second byte is fetched
    logic [5:0] op_q;
    logic [1:0] rd_q;
    logic       branch_q;
    logic [7:0] imm_q;
    logic       taken;

    instr_decoder u_decoder (
        .instr_byte (instr_byte),
        .opcode     (dec_opcode),
        .rd         (dec_rd),
        .rs         (dec_rs),
        .two_byte   (dec_two_byte),
        .branch     (dec_branch),
        .legal      (dec_legal)
    );

    // Branch resolution; flags are only consulted while in BRANCH
    assign taken = (op_q == OP_BRA)
                 | ((op_q == OP_BHI) & flag_hi)
                 | ((op_q == OP_BEQ) & flag_z);

    // Sequencer FSM with registered PC, micro-op outputs, illegal pulse and retire counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            uop_valid  <= 1'b0;
            uop_opcode <= '0;
            uop_rd     <= '0;
            uop_rs     <= '0;
            uop_imm    <= '0;
            illegal    <= 1'b0;
            retired    <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            branch_q   <= 1'b0;
            imm_q      <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        pc <= pc + ADDR_W'(1);
                        if (!dec_legal) begin
                            // Undefined byte is skipped without retiring
                            illegal <= 1'b1;
                        end else if (dec_two_byte) begin
                            op_q     <= dec_opcode;
                            rd_q     <= dec_rd;
                            branch_q <= dec_branch;
                            state    <= ST_FETCH_IMM;
                        end else begin
                            uop_opcode <= dec_opcode;
                            uop_rd     <= dec_rd;
                            uop_rs     <= dec_rs;
                            uop_imm    <= '0;
                            uop_valid  <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_FETCH_IMM: begin
                    pc    <= pc + ADDR_W'(1);
                    imm_q <= instr_byte;
                    if (branch_q) begin
                        state <= ST_BRANCH;
                    end else begin
                        uop_opcode <= op_q;
                        uop_rd     <= rd_q;
                        uop_rs     <= '0;
                        uop_imm    <= instr_byte;
                        uop_valid  <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (uop_ready) begin
                        uop_valid <= 1'b0;
                        retired   <= retired + CNT_W'(1);
                        state     <= ST_FETCH;
                    end
                end
                ST_BRANCH: begin
                    if (taken) begin
                        pc <= ADDR_W'(imm_q);
                    end
                    retired <= retired + CNT_W'(1);
                    state   <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/issue controller for the 8-bit accumulator-style CPU.
- Drives the program memory address bus and assembles 1- or 2-byte instructions from the combinational ROM read port.
- Resolves BRA/BHI/BEQ internally from datapath flags and hands every other instruction to the register/ALU datapath over a valid/ready micro-op interface.

Parameters:
- ADDR_W, 8, program counter and address bus width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- run  in  1  1 = sequencer may leave FETCH; 0 = hold in FETCH, PC frozen.
- pc  out  ADDR_W  program memory address (drives address_bus).
- instr_byte  in  8  program memory data (data_bus), combinational on pc.
- uop_valid  out  1  micro-op presented to datapath.
- uop_ready  in  1  datapath accepts micro-op.
- uop_opcode  out  6  normalized opcode: 4-bit ops zero-extended as {2'b00,op[3:0]}, 6-bit ops as-is.
- uop_rd  out  2  destination/first register field.
- uop_rs  out  2  source register field (0 for 6-bit-opcode forms).
- uop_imm  out  8  second byte (LD_IMM value, CMP operand); 0 for 1-byte ops.
- flag_z  in  1  datapath zero flag from last CMP/arith.
- flag_hi  in  1  datapath "unsigned higher" flag from last CMP.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- retired  out  CNT_W  count of completed instructions (issued handshakes plus resolved branches).

Behaviour:
- Reset (reset==0 at clk edge) forces: pc=RESET_PC, state=FETCH, uop_valid=0, uop_opcode/rd/rs/imm=0, illegal=0, retired=0. Applies in any state, including mid-handshake; a pending micro-op is dropped.
- Decode:
  - byte[7]==0 → 4-bit op = byte[7:4], rd = byte[3:2], rs = byte[1:0].
  - byte[7]==1 → 6-bit op = byte[7:2], rd = byte[1:0].
- Legal 4-bit ops: ADD 0000, SUB 0001, MUL 0010, MOV 0100, NOP 0111.
- Legal 6-bit ops: LD_IMM 100000, CMP 100011, DEC 100101, INPUT 100110, OUTPUT 100111, BRA 101010, BHI 101100, BEQ 101101.
- Two-byte ops: LD_IMM, CMP, BRA, BHI, BEQ. All others are one byte.
- States:
  - FETCH: if run, latch instr_byte into IR and set pc=pc+1. Next state:
    - illegal opcode → pulse illegal, remain in FETCH (byte skipped as NOP, retired unchanged);
    - two-byte op → FETCH_IMM;
    - otherwise → ISSUE.
  - FETCH_IMM: latch instr_byte into IMM, pc=pc+1. Branch → BRANCH, else → ISSUE.
  - ISSUE: uop_valid=1 with outputs stable. On uop_valid&&uop_ready: retired+1, → FETCH. Outputs must not change while valid and not ready.
  - BRANCH: taken = BRA | (BHI & flag_hi) | (BEQ & flag_z). If taken, pc=IMM; else pc unchanged. retired+1, → FETCH. No micro-op issued.
- Latency: 1-byte op = FETCH + ISSUE, 2 cycles minimum. 2-byte op = 3 cycles minimum. Branch = exactly 3 cycles.
- Flag contract: the datapath must have flags updated no later than the cycle after the CMP handshake. The sequencer samples flags only in BRANCH, which is always at least 2 cycles after any prior handshake.
- pc arithmetic is modulo 2^ADDR_W: 255+1 wraps to 0, and a 2-byte op at 255 takes its immediate from address 0.
- retired wraps at 2^CNT_W−1 → 0.
- run=0 is honoured only in FETCH; an instruction already in progress completes.
- uop_ready while uop_valid=0 is ignored.

Decomposition:
- Shared package: opcode constants (4- and 6-bit), state encoding, and an is_two_byte/is_branch/is_legal decode function.
- Natural sub-module: instr_decoder, combinational, byte → {opcode6, rd, rs, two_byte, branch, legal}. The FSM and counters stay in instr_sequencer.

Test Plan:
- Reset mid-ISSUE with uop_ready=0 held → next cycle pc=0, uop_valid=0, retired=0, state FETCH.
- ROM[0..1]={LD_IMM r0, 8'd5}, uop_ready=1 → uop_valid high in cycle 3 with opcode=100000, rd=0, imm=5; pc=2; retired=1.
- ADD r1,r2 (8'h06) with uop_ready low for 4 cycles → uop_valid and outputs held stable for all 4 cycles; single retire on the accept edge; pc advances by exactly 1.
- CMP then BHI →37 with flag_hi=1 → pc=37. Repeat with flag_hi=0 → pc = branch address+2. BEQ with flag_z=1 → pc=target. BRA → always target. No uop_valid during any branch.
- Byte 8'hFC (undefined) at pc=10 → illegal pulse for 1 cycle, pc=11, no uop_valid, retired unchanged.
- LD_IMM at pc=255 with ROM[0]=8'h2A → uop_imm=42, pc wraps to 1. With run=0 in FETCH → pc unchanged across 10 cycles.
